// File: rtl/mem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_pkg: shared encodings for the fixed-latency memory controller
// Rev 1.0
// ------------------------------------------------------------------
package mem_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_word_array: 1R/1W synchronous word array with registered read data
// Rev 1.0
// ------------------------------------------------------------------
module mem_word_array
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int WIDTH     = WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/mem_latency_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_latency_ctrl: CPU-side word memory with fixed, parameterized latency
// Rev 1.0
// ------------------------------------------------------------------
module mem_latency_ctrl
  import mem_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] txn_count,
  output logic                 protocol_err
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                 state, state_next;
  op_t                    op;
  logic [3:0]             cnt;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic [WORD_SIZE-1:0]   rd_data;
  logic                   req_read, req_write, commit, mem_we, mem_re;
  logic                   unused_addr;

  assign req_read    = readM & ~writeM;
  assign req_write   = writeM & ~readM;
  assign commit      = (state == ST_BUSY) && (cnt == 4'd0);
  // Gating with reset keeps a write interrupted on its commit edge out of the array.
  assign mem_we      = commit && (op == OP_WRITE) && !reset;
  assign mem_re      = commit && (op == OP_READ);
  assign unused_addr = ^address[WORD_SIZE-1:ADDR_BITS];

  assign data = inputReady ? rd_data : {WORD_SIZE{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: if (req_read || req_write) state_next = ST_BUSY;
      ST_BUSY: begin
        busy = 1'b1;
        if (cnt == 4'd0) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        inputReady = (op == OP_READ);
        ackOutput  = (op == OP_WRITE);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= 4'd0;
      op           <= OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      txn_count    <= '0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (readM && writeM) begin
            protocol_err <= 1'b1;
          end else if (req_read || req_write) begin
            cnt    <= CNT_LOAD;
            addr_q <= address[ADDR_BITS-1:0];
            op     <= req_write ? OP_WRITE : OP_READ;
            if (req_write) wdata_q <= data;
          end
        end
        ST_BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        ST_DONE: txn_count <= txn_count + 16'd1;
        default: ;
      endcase
    end
  end

  mem_word_array #(
    .ADDR_BITS(ADDR_BITS),
    .WIDTH    (WORD_SIZE)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(addr_q),
    .wdata(wdata_q),
    .re   (mem_re),
    .raddr(addr_q),
    .rdata(rd_data)
  );

endmodule
`default_nettype wire
